sync_fifo: RTL and testbench

- Single-clock synchronous FIFO buffering byte-wide data between a producer and a consumer in the DRAM-cache datapath.
- Provides full/empty status plus almost-full/almost-empty early-warning flags for flow control.
- Read data is registered and appears one cycle after an accepted read.

---
 rtl/sync_fifo.sv | 88 ++++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data and
// registered full/empty/almost-full/almost-empty flags.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  full,
    output logic                  A_full,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  empty,
    output logic                  A_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered flags, i.e. pre-edge state.
    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    // Occupancy after this edge; flags are decoded from it.
    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Pointers, occupancy, registered read data and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            read_data <= '0;
            full      <= 1'b0;
            A_full    <= 1'b0;
            empty     <= 1'b1;
            A_empty   <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                read_data <= mem[rd_ptr];
            end
            count   <= count_nxt;
            full    <= (count_nxt == CNT_FULL);
            empty   <= (count_nxt == '0);
            A_full  <= (count_nxt >= AF_LVL);
            A_empty <= (count_nxt <= AE_LVL);
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int AEM   = 2;

    logic          clk;
    logic          reset;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          full;
    logic          A_full;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic          empty;
    logic          A_empty;

    int checks;
    int failures;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AF_MARGIN(AFM),
        .AE_MARGIN(AEM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write_en(write_en),
        .write_data(write_data),
        .full(full),
        .A_full(A_full),
        .read_en(read_en),
        .read_data(read_data),
        .empty(empty),
        .A_empty(A_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".full"},    32'(full),    32'(n == DEPTH));
        check({tag, ".empty"},   32'(empty),   32'(n == 0));
        check({tag, ".A_full"},  32'(A_full),  32'(n >= DEPTH - AFM));
        check({tag, ".A_empty"}, 32'(A_empty), 32'(n <= AEM));
        check({tag, ".rdata"},   32'(read_data), 32'(m_rdata));
    endtask

    // One clock: drive, apply model on the edge, check 1ns later.
    task automatic cyc(input logic we, input logic [DW-1:0] wd,
                       input logic re, input string tag);
        bit wa;
        bit ra;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        wa = we && (q.size() < DEPTH);
        ra = re && (q.size() > 0);
        if (ra) m_rdata = q.pop_front();
        if (wa) q.push_back(wd);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = '0;
        model_reset();

        // Reset
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rel");

        // Single write then read
        cyc(1'b1, 8'h01, 1'b0, "single_wr");
        check("single_wr.empty0", 32'(empty), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, "single_rd");
        check("single_rd.data", 32'(read_data), 32'h01);
        check("single_rd.empty1", 32'(empty), 32'd1);

        // Fill with 0x00..0x0F, then overflow attempt
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(i), 1'b0, "fill");
        end
        check("fill.full", 32'(full), 32'd1);
        cyc(1'b1, 8'hFF, 1'b0, "overflow");

        // Drain, then underflow attempt
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, "drain");
            check("drain.order", 32'(read_data), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b1, "underflow");
        check("underflow.hold", 32'(read_data), 32'h0F);

        // Preload 8, then simultaneous access across wrap
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, DW'(8'h40 + i), 1'b0, "preload");
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DW'(8'h80 + i), 1'b1, "simul");
        end
        check("simul.count8", 32'(q.size()), 32'd8);

        // Top up to full, then read+write while full
        while (q.size() < DEPTH) begin
            cyc(1'b1, DW'($urandom), 1'b0, "topup");
        end
        cyc(1'b1, 8'hEE, 1'b1, "rw_full");
        check("rw_full.nfull", 32'(full), 32'd0);

        // Drain empty, then read+write while empty
        while (q.size() > 0) begin
            cyc(1'b0, 8'h00, 1'b1, "drain2");
        end
        cyc(1'b1, 8'h5A, 1'b1, "rw_empty");
        check("rw_empty.nempty", 32'(empty), 32'd0);

        // Async reset mid-fill with 5 entries stored
        while (q.size() < 5) begin
            cyc(1'b1, DW'($urandom), 1'b0, "midfill");
        end
        cyc(1'b0, 8'h00, 1'b1, "midfill_rd");
        cyc(1'b1, 8'h33, 1'b0, "midfill_wr");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all("async_rel");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic we;
            logic re;
            int   bias;
            bias = (i / 50) % 2;
            we = ($urandom_range(0, 99) < (bias ? 70 : 35));
            re = ($urandom_range(0, 99) < (bias ? 35 : 70));
            cyc(we, DW'($urandom), re, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
